ram_1w_1rs_banked: RTL and testbench
====================================

Name: ram_1w_1rs_banked

Overview:
- Single-clock, one-write/one-read-port RAM built from N banks of the 32x256 sky130 SRAM macro (1rw1r).
- Port 0 of each macro is write-only; port 1 is read-only.
- Adds byte-masked writes, bank decode, a registered read pipeline with a valid flag, and optional write-first forwarding on address collision.
- Sits between user-project datapaths (FIFOs, buffers) and the SRAM macros; replaces the flat single-macro wrapper where depth above 256 or defined collision behaviour is required.

Parameters:
- wordCount, 512, total words; one of 256/512/1024/2048; bankCount = wordCount/256.
- wordWidth, 32, data width; fixed at 32 (macro width).
- maskWidth, 4, byte-enable width; fixed at wordWidth/8.
- addressWidth, 9, log2(wordCount).
- readUnderWrite, "dontCare", "dontCare" or "writeFirst".
- outputReg, 1, 1 = extra output register stage (latency 3); 0 = latency 2.

Ports:
- clk  in  1  single clock; drives all macros and pipeline registers.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_mask  in  maskWidth  byte enables; bit i enables wr_data[8i+7:8i].
- wr_addr  in  addressWidth  write word address.
- wr_data  in  wordWidth  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  addressWidth  read word address.
- rd_data  out  wordWidth  read data; valid only while rd_valid=1.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.
- rd_collision  out  1  pulses together with rd_valid when that read collided with a same-cycle write to the same address.

Behaviour:
- Reset is asynchronous and active-low: clk single clock, resetn asserted low clears state immediately, release is synchronous to clk.
- Reset values: rd_data=0, rd_valid=0, rd_collision=0; all pipeline valid bits, bank-select registers and forwarding registers cleared.
- While resetn=0, every macro csb0/csb1 is held high (no access). SRAM contents are not cleared.
- Bank decode: bank = addr[addressWidth-1:8]; macro address = addr[7:0]. With bankCount=1 there is no decode.
- Write: on the rising edge with wr_en=1, only the selected bank gets csb0=0 and web0=0, with wmask0=wr_mask.
  - wr_mask=0 with wr_en=1 is a legal no-op; the bank is still selected.
- Read pipeline:
  - S0 (cycle N): rd_en=1 selects one bank (csb1=0). The bank index, collision flag and forwarding data are registered.
  - S1 (cycle N+1): macro dout1 is valid; the delayed bank index drives the output mux.
  - S2 (cycle N+2): the muxed and merged word is registered into rd_data with rd_valid=1 (outputReg=0).
  - outputReg=1 adds one more register stage, so rd_valid/rd_data appear at N+3.
- Reads are fully pipelined: back-to-back rd_en every cycle gives rd_valid every cycle, in order.
- rd_data holds its last value when rd_valid=0.
- Collision: wr_en & rd_en & (wr_addr==rd_addr) in the same cycle.
  - "dontCare": rd_data is the raw macro output (undefined on collision); rd_collision=1 flags it.
  - "writeFirst": for each byte with wr_mask[i]=1, rd_data byte i = wr_data byte i from the colliding cycle. Bytes with wr_mask[i]=0 come from macro dout1; the macro conflict is per byte column, so these bytes hold old data. rd_collision=1.
- A write in cycle N followed by a read of the same address in cycle N+1 or later returns the new data; no forwarding is involved.
- Reset mid-operation: in-flight reads are dropped; no rd_valid is produced for them after release.
- Address width is exact, so there are no out-of-range addresses.
- Elaboration check: an illegal wordCount or readUnderWrite value is a fatal elaboration error.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with rd_en=1 and wr_en=1 -> rd_valid=0, rd_data=0 throughout; after release, reading address 0x005 does not return the write attempted during reset.
- Bank crossing (wordCount=512): write 0xA5A5A5A5 at 0x0FF and 0x5A5A5A5A at 0x100, then read both back-to-back -> rd_valid on 2 consecutive cycles, data in order, latency 3 (outputReg=1) and 2 (outputReg=0).
- Byte mask: write 0x11223344 mask 0xF at 0x020, then 0xAABBCCDD mask 0x5 -> read returns 0x11BB33DD.
- Collision, writeFirst: preload 0x11223344 at 0x040; same cycle write 0xAABBCCDD mask 0x3 and read 0x040 -> rd_data=0x1122CCDD, rd_collision=1.
- Collision, dontCare: same stimulus -> rd_collision=1, rd_data not checked; a subsequent read returns 0x1122CCDD.
- Streaming: 256 consecutive reads across all 4 banks (wordCount=1024) with random concurrent non-colliding writes -> 256 rd_valid pulses, data matches the scoreboard, no gaps.

Source files
------------

// File: rtl/ram_1w_1rs_banked.sv
// Banked one-write/one-read RAM built from 32x256 dual-port SRAM macros.
// Adds byte-masked writes, bank decode, a pipelined read path and optional write-first forwarding.

// Behavioural stand-in for the sky130 32x256 1rw1r macro: port 0 used write-only, port 1 read-only.
module sram_macro_32x256 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [7:0]  addr0,
  input  logic [31:0] din0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [7:0]  addr1,
  output logic [31:0] dout1
);

  logic [31:0] mem [256];

  // NOTE: the storage array has no reset; SRAM contents survive resetn.
  always_ff @(posedge clk0) begin
    if (!csb0 && !web0) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
      end
    end
  end

  // A same-cycle write to the addressed word is not visible here: port 1 returns the old word.
  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

module ram_1w_1rs_banked #(
  parameter int    wordCount      = 512,
  parameter int    wordWidth      = 32,
  parameter int    maskWidth      = wordWidth / 8,
  parameter int    addressWidth   = $clog2(wordCount),
  parameter string readUnderWrite = "dontCare",
  parameter bit    outputReg      = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [maskWidth-1:0]    wr_mask,
  input  logic [addressWidth-1:0] wr_addr,
  input  logic [wordWidth-1:0]    wr_data,
  input  logic                    rd_en,
  input  logic [addressWidth-1:0] rd_addr,
  output logic [wordWidth-1:0]    rd_data,
  output logic                    rd_valid,
  output logic                    rd_collision
);

  localparam int bank_count  = wordCount / 256;
  localparam int bank_bits   = (bank_count > 1) ? $clog2(bank_count) : 1;
  localparam bit write_first = (readUnderWrite == "writeFirst");

  generate
    if (!(wordCount == 256 || wordCount == 512 || wordCount == 1024 || wordCount == 2048)) begin : g_bad_count
      $fatal(1, "ram_1w_1rs_banked: wordCount must be 256, 512, 1024 or 2048");
    end
    if (!(readUnderWrite == "dontCare" || readUnderWrite == "writeFirst")) begin : g_bad_ruw
      $fatal(1, "ram_1w_1rs_banked: readUnderWrite must be \"dontCare\" or \"writeFirst\"");
    end
    if (wordWidth != 32 || maskWidth != wordWidth / 8 || addressWidth != $clog2(wordCount)) begin : g_bad_width
      $fatal(1, "ram_1w_1rs_banked: inconsistent width parameters");
    end
  endgenerate

  logic [bank_bits-1:0] wr_bank, rd_bank;

  generate
    if (bank_count > 1) begin : g_decode
      assign wr_bank = wr_addr[addressWidth-1:8];
      assign rd_bank = rd_addr[addressWidth-1:8];
    end else begin : g_no_decode
      assign wr_bank = '0;
      assign rd_bank = '0;
    end
  endgenerate

  // Padded to a power of two so the delayed bank index can select without a width mismatch.
  logic [wordWidth-1:0] bank_dout [2**bank_bits];

  generate
    for (genvar b = 0; b < 2**bank_bits; b++) begin : g_bank
      if (b < bank_count) begin : g_macro
        logic csb0, csb1;
        assign csb0 = !(resetn && wr_en && (wr_bank == bank_bits'(b)));
        assign csb1 = !(resetn && rd_en && (rd_bank == bank_bits'(b)));

        sram_macro_32x256 u_sram (
          .clk0   (clk),
          .csb0   (csb0),
          .web0   (1'b0),
          .wmask0 (wr_mask),
          .addr0  (wr_addr[7:0]),
          .din0   (wr_data),
          .clk1   (clk),
          .csb1   (csb1),
          .addr1  (rd_addr[7:0]),
          .dout1  (bank_dout[b])
        );
      end else begin : g_pad
        assign bank_dout[b] = '0;
      end
    end
  endgenerate

  logic collision;
  assign collision = wr_en && rd_en && (wr_addr == rd_addr);

  // S0 -> S1: capture what the macro output will need one cycle later.
  logic                 s1_valid, s1_coll;
  logic [bank_bits-1:0] s1_bank;
  logic [maskWidth-1:0] s1_fwd_mask;
  logic [wordWidth-1:0] s1_fwd_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid    <= 1'b0;
      s1_coll     <= 1'b0;
      s1_bank     <= '0;
      s1_fwd_mask <= '0;
      s1_fwd_data <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_bank     <= rd_bank;
        s1_coll     <= collision;
        s1_fwd_mask <= (write_first && collision) ? wr_mask : '0;
        s1_fwd_data <= wr_data;
      end
    end
  end

  // Forwarded bytes replace the stale macro bytes; unmasked bytes keep the old word.
  logic [wordWidth-1:0] merged;

  always_comb begin
    // NOTE: merged takes a full default first so no path leaves it unassigned.
    merged = bank_dout[s1_bank];
    for (int i = 0; i < maskWidth; i++) begin
      if (s1_fwd_mask[i]) merged[8*i +: 8] = s1_fwd_data[8*i +: 8];
    end
  end

  logic                 s2_valid, s2_coll;
  logic [wordWidth-1:0] s2_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_coll  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_coll  <= s1_valid && s1_coll;
      if (s1_valid) s2_data <= merged;
    end
  end

  generate
    if (outputReg) begin : g_out_reg
      logic                 s3_valid, s3_coll;
      logic [wordWidth-1:0] s3_data;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s3_valid <= 1'b0;
          s3_coll  <= 1'b0;
          s3_data  <= '0;
        end else begin
          s3_valid <= s2_valid;
          s3_coll  <= s2_coll;
          if (s2_valid) s3_data <= s2_data;
        end
      end

      assign rd_data      = s3_data;
      assign rd_valid     = s3_valid;
      assign rd_collision = s3_coll;
    end else begin : g_no_out_reg
      assign rd_data      = s2_data;
      assign rd_valid     = s2_valid;
      assign rd_collision = s2_coll;
    end
  endgenerate

endmodule

// File: tb/tb_ram_1w_1rs_banked.sv
// Directed bench for ram_1w_1rs_banked: two configurations share one stimulus stream,
// each output checked every cycle against an expected-read queue stamped with its due cycle.
module tb_ram_1w_1rs_banked;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_mask = '0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;

  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        rd_collision_a, rd_collision_b;

  always #5 clk = ~clk;

  // 1024 words, write-first, latency 3.
  ram_1w_1rs_banked #(
    .wordCount(1024), .addressWidth(10), .readUnderWrite("writeFirst"), .outputReg(1'b1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .rd_collision(rd_collision_a)
  );

  // 512 words, dont-care, latency 2.
  ram_1w_1rs_banked #(
    .wordCount(512), .addressWidth(9), .readUnderWrite("dontCare"), .outputReg(1'b0)
  ) dut_b (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr[8:0]),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr[8:0]), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .rd_collision(rd_collision_b)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        chk;
    logic        coll;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] model [1024];
  int          n_checks = 0;
  int          n_fail = 0;
  int          tick_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (tick %0d)", tag, obs, exp, tick_n);
    end
  endtask

  task automatic check_outs();
    exp_t e;
    if (!resetn) begin
      check("a_rst_valid", 32'(rd_valid_a), 32'd0);
      check("a_rst_coll", 32'(rd_collision_a), 32'd0);
      check("a_rst_data", rd_data_a, 32'd0);
      check("b_rst_valid", 32'(rd_valid_b), 32'd0);
      check("b_rst_coll", 32'(rd_collision_b), 32'd0);
      check("b_rst_data", rd_data_b, 32'd0);
      return;
    end
    if (q_a.size() > 0 && q_a[0].due == tick_n) begin
      e = q_a.pop_front();
      check("a_valid", 32'(rd_valid_a), 32'd1);
      check("a_coll", 32'(rd_collision_a), 32'(e.coll));
      if (e.chk) check("a_data", rd_data_a, e.data);
    end else begin
      check("a_idle", {30'd0, rd_valid_a, rd_collision_a}, 32'd0);
    end
    if (q_b.size() > 0 && q_b[0].due == tick_n) begin
      e = q_b.pop_front();
      check("b_valid", 32'(rd_valid_b), 32'd1);
      check("b_coll", 32'(rd_collision_b), 32'(e.coll));
      if (e.chk) check("b_data", rd_data_b, e.data);
    end else begin
      check("b_idle", {30'd0, rd_valid_b, rd_collision_b}, 32'd0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tick_n++;
    check_outs();
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic expect_rd(input logic [31:0] da, input logic ca, input logic chk_b,
                           input logic [31:0] db, input logic cb);
    q_a.push_back('{due: tick_n + 3, data: da, chk: 1'b1, coll: ca});
    q_b.push_back('{due: tick_n + 2, data: db, chk: chk_b, coll: cb});
  endtask

  task automatic write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m; rd_en = 1'b0;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic read(input logic [9:0] a, input logic [31:0] d);
    rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
    expect_rd(d, 1'b0, 1'b1, d, 1'b0);
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic model_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int j = 0; j < 4; j++) begin
      if (m[j]) model[a][8*j +: 8] = d[8*j +: 8];
    end
  endtask

  initial begin
    // Power-on reset with a guaranteed falling edge.
    #3 resetn = 1'b0;
    repeat (3) cyc();
    resetn = 1'b1;
    idle(2);

    // Known word at 0x005, then a read that is in flight when reset hits.
    write(10'h005, 32'h12345678, 4'hF);
    read(10'h005, 32'h12345678);
    idle(4);
    rd_en = 1'b1; rd_addr = 10'h005;
    cyc();
    resetn = 1'b0;
    #1;
    check("a_async_rst_data", rd_data_a, 32'd0);
    check("b_async_rst_data", rd_data_b, 32'd0);
    check("a_async_rst_valid", 32'(rd_valid_a), 32'd0);
    wr_en = 1'b1; wr_addr = 10'h005; wr_data = 32'hDEADBEEF; wr_mask = 4'hF;
    rd_en = 1'b1; rd_addr = 10'h005;
    repeat (3) cyc();
    rd_en = 1'b0; wr_en = 1'b0;
    resetn = 1'b1;
    idle(3);
    read(10'h005, 32'h12345678);
    idle(4);

    // Bank crossing, back-to-back reads, then hold of the last word.
    write(10'h0FF, 32'hA5A5A5A5, 4'hF);
    write(10'h100, 32'h5A5A5A5A, 4'hF);
    read(10'h0FF, 32'hA5A5A5A5);
    read(10'h100, 32'h5A5A5A5A);
    idle(5);
    check("a_hold", rd_data_a, 32'h5A5A5A5A);
    check("b_hold", rd_data_b, 32'h5A5A5A5A);

    // Byte mask, then a zero-mask write that must change nothing.
    write(10'h020, 32'h11223344, 4'hF);
    write(10'h020, 32'hAABBCCDD, 4'h5);
    read(10'h020, 32'h11BB33DD);
    write(10'h020, 32'hFFFFFFFF, 4'h0);
    read(10'h020, 32'h11BB33DD);
    idle(4);

    // Same-cycle write and read of 0x040.
    write(10'h040, 32'h11223344, 4'hF);
    wr_en = 1'b1; wr_addr = 10'h040; wr_data = 32'hAABBCCDD; wr_mask = 4'h3;
    rd_en = 1'b1; rd_addr = 10'h040;
    expect_rd(32'h1122CCDD, 1'b1, 1'b0, 32'h0, 1'b1);
    cyc();
    rd_en = 1'b0; wr_en = 1'b0;
    read(10'h040, 32'h1122CCDD);
    idle(4);

    // Streaming: preload 256 words spread over all four banks, then read them every cycle
    // while unrelated writes land elsewhere.
    for (int i = 0; i < 256; i++) begin
      logic [7:0]  iv;
      logic [9:0]  a;
      logic [31:0] d;
      iv = 8'(i);
      a = {iv[1:0], iv};
      d = $urandom;
      model_write(a, d, 4'hF);
      write(a, d, 4'hF);
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0]  iv;
      logic [9:0]  wa;
      logic [31:0] wd;
      logic [3:0]  wm;
      iv = 8'(i);
      rd_en = 1'b1;
      rd_addr = {iv[1:0], iv};
      q_a.push_back('{due: tick_n + 3, data: model[rd_addr], chk: 1'b1, coll: 1'b0});
      q_b.push_back('{due: tick_n + 2, data: 32'h0, chk: 1'b0, coll: 1'b0});
      do wa = 10'($urandom_range(0, 1023)); while (wa[8:0] == rd_addr[8:0]);
      wd = $urandom;
      wm = 4'($urandom_range(0, 15));
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = wa; wr_data = wd; wr_mask = wm;
      if (wr_en) model_write(wa, wd, wm);
      cyc();
    end
    idle(5);
    check("a_drained", q_a.size(), 32'd0);
    check("b_drained", q_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
